// File: rtl/alu_uart_cmd_ctrl.sv
// alu_uart_cmd_ctrl
//   Command sequencer between a UART RX/TX pair and an 8-bit ALU.
//   Frames from the receiver:
//     CMD_CONFIG, A, B, OP : load the ALU operands and opcode. One cycle
//                            later, latch the ALU result and flags.
//     CMD_DISPLAY          : send the latched result byte, then the flags byte.
//
// Ports
//   clk          system clock
//   tb_reset     asynchronous, active-low reset
//   rx_data      received byte, qualified by rx_valid
//   rx_valid     1-cycle pulse
//   tx_data      byte to transmit, held until the matching tx_done
//   tx_start     1-cycle pulse, starts transmission of tx_data
//   tx_done      1-cycle pulse, transmitter finished the stop bit
//   alu_a/alu_b  registered operands
//   alu_op       registered opcode (low OP_W bits of the op byte)
//   alu_result   combinational ALU result
//   alu_zero/alu_ovf/alu_carry   ALU flags
//   leds         latched result
//   frame_err    1-cycle pulse: timeout, unknown command, or dropped byte
//   state_dbg    current FSM state (IDLE=0 ... WAIT_FLG=8)
//
// Handshake: neither side can stall the other. An rx_valid pulse offers one
// byte for exactly one cycle. A byte that arrives in a state that cannot take
// it is dropped and flagged on frame_err. tx_start is issued once per byte.
// tx_data then holds steady until the transmitter answers with tx_done.
module alu_uart_cmd_ctrl #(
  parameter int                DATA_W       = 8,
  parameter int                OP_W         = 6,
  parameter logic [DATA_W-1:0] CMD_CONFIG   = 8'hCD,
  parameter logic [DATA_W-1:0] CMD_DISPLAY  = 8'hD1,
  parameter int                TIMEOUT_CLKS = 2_000_000
) (
  input  logic              clk,
  input  logic              tb_reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  input  logic              alu_carry,
  output logic [DATA_W-1:0] leds,
  output logic              frame_err,
  output logic [3:0]        state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_A    = 4'd1,
    GET_B    = 4'd2,
    GET_OP   = 4'd3,
    LATCH    = 4'd4,
    SEND_RES = 4'd5,
    WAIT_RES = 4'd6,
    SEND_FLG = 4'd7,
    WAIT_FLG = 4'd8
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] flags_q;
  logic              drop_state;

  assign state_dbg = state;

  // States in which an incoming byte has nowhere to go.
  always_comb begin
    drop_state = 1'b0;
    case (state)
      LATCH, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG: drop_state = 1'b1;
      default:                                       drop_state = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge tb_reset) begin
    if (!tb_reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      leds      <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_CONFIG) begin
              state   <= GET_A;
              tmo_cnt <= '0;
            end else if (rx_data == CMD_DISPLAY) begin
              state <= SEND_RES;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        // Inside a frame every byte is data, command values included.
        GET_A, GET_B, GET_OP: begin
          if (rx_valid) begin
            tmo_cnt <= '0;
            case (state)
              GET_A:   begin alu_a  <= rx_data;             state <= GET_B;  end
              GET_B:   begin alu_b  <= rx_data;             state <= GET_OP; end
              default: begin alu_op <= rx_data[OP_W-1:0];   state <= LATCH;  end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            // Abandon the frame. Operands already loaded stay as they are.
            frame_err <= 1'b1;
            tmo_cnt   <= '0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        // The operands registered on the previous edge are now on the ALU.
        LATCH: begin
          result_q <= alu_result;
          flags_q  <= {{(DATA_W-3){1'b0}}, alu_carry, alu_ovf, alu_zero};
          leds     <= alu_result;
          state    <= IDLE;
        end
        SEND_RES: begin
          tx_data  <= result_q;
          tx_start <= 1'b1;
          state    <= WAIT_RES;
        end
        WAIT_RES: if (tx_done) state <= SEND_FLG;
        SEND_FLG: begin
          tx_data  <= flags_q;
          tx_start <= 1'b1;
          state    <= WAIT_FLG;
        end
        WAIT_FLG: if (tx_done) state <= IDLE;
        default:  state <= IDLE;
      endcase
      if (rx_valid && drop_state) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_uart_cmd_ctrl.sv
// Testbench for alu_uart_cmd_ctrl. An ALU model and a transmitter responder
// stand in for the surroundings. A reference model of the register and TX
// contents is built from the command rules.
module tb_alu_uart_cmd_ctrl;

  localparam int W = 8;
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_GET_B    = 4'd2;
  localparam logic [3:0] ST_WAIT_RES = 4'd6;
  localparam logic [3:0] ST_WAIT_FLG = 4'd8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic tb_reset = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] rx_data = '0;
  logic         rx_valid = 1'b0;
  logic [W-1:0] tx_data;
  logic         tx_start;
  logic         tx_done = 1'b0;
  logic [W-1:0] alu_a, alu_b, alu_result, leds;
  logic [5:0]   alu_op;
  logic         alu_zero, alu_ovf, alu_carry, frame_err;
  logic [3:0]   state_dbg;

  alu_uart_cmd_ctrl #(.TIMEOUT_CLKS(1000)) dut (
    .clk(clk), .tb_reset(tb_reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_carry(alu_carry),
    .leds(leds), .frame_err(frame_err), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- ALU environment (also used by the model) ----------------
  // Returns {carry, ovf, zero, result}.
  function automatic logic [10:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    int ua, ub, sa, sb, u, s;
    logic [7:0] r;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    u = 0; s = 0; c = 1'b0; v = 1'b0; r = a;
    case (op)
      6'h20: begin u = ua + ub; s = sa + sb; r = u[7:0]; c = (u > 255); v = (s > 127) || (s < -128); end
      6'h22: begin u = ua - ub; s = sa - sb; r = u[7:0]; c = (ua < ub);  v = (s > 127) || (s < -128); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      default: r = a;
    endcase
    return {c, v, (r == 8'h00), r};
  endfunction

  always_comb {alu_carry, alu_ovf, alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_op);

  // ---------------- reference model ----------------
  logic [W-1:0] exp_a = '0, exp_b = '0, exp_res = '0, exp_flags = '0;
  logic [5:0]   exp_op = '0;
  logic [W-1:0] exp_q[$];
  int           fe_cnt = 0;
  logic         tx_busy = 1'b0;

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  task automatic model_reset();
    exp_a = '0; exp_b = '0; exp_op = '0; exp_res = '0; exp_flags = '0;
    exp_q.delete();
  endtask

  // ---------------- transmitter responder / TX scoreboard ----------------
  initial begin
    logic [W-1:0] held, e;
    int n;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && tb_reset) begin
        tx_busy = 1'b1;
        if (exp_q.size() == 0) check("tx_unexpected", tx_start, 0);
        else begin
          e = exp_q.pop_front();
          check("tx_byte", tx_data, e);
        end
        held = tx_data;
        n = $urandom_range(4, 8);
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          if (!tb_reset) break;
          check("tx_hold", tx_data, held);
          check("tx_start_once", tx_start, 0);
        end
        if (tb_reset) begin
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
        end
        tx_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [W-1:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] st);
    int k;
    for (k = 0; k < 300; k++) begin
      if (state_dbg == st) break;
      @(negedge clk);
    end
    check(tag, (k < 300), 1);
  endtask

  task automatic wait_tx_done(input string tag);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_busy && state_dbg == ST_IDLE) break;
    end
    check(tag, (k < 400), 1);
  endtask

  task automatic do_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] opb);
    logic [10:0] r;
    send_byte(8'hCD); idle($urandom_range(0, 4));
    send_byte(a);     idle($urandom_range(0, 4));
    send_byte(b);     idle($urandom_range(0, 4));
    send_byte(opb);
    // Operands are loaded; the result has not been latched yet.
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_op", alu_op, opb[5:0]);
    check("leds_before_latch", leds, exp_res);
    exp_a = a; exp_b = b; exp_op = opb[5:0];
    r = alu_fn(a, b, opb[5:0]);
    exp_res = r[7:0];
    exp_flags = {5'b0, r[10:8]};
    @(negedge clk);
    check("leds", leds, exp_res);
    check("state_after_latch", state_dbg, ST_IDLE);
  endtask

  task automatic do_display();
    exp_q.push_back(exp_res);
    exp_q.push_back(exp_flags);
    send_byte(8'hD1);
    wait_tx_done("display_complete");
  endtask

  task automatic do_junk();
    logic [W-1:0] b;
    int fe0;
    b = 8'(($urandom_range(0, 255)));
    while (b == 8'hCD || b == 8'hD1) b = 8'(($urandom_range(0, 255)));
    fe0 = fe_cnt;
    send_byte(b);
    idle(1);
    check("junk_frame_err", fe_cnt - fe0, 1);
    check("junk_state", state_dbg, ST_IDLE);
    check("junk_alu_a", alu_a, exp_a);
    check("junk_leds", leds, exp_res);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] ops[6];
    int fe0;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h3F};

    idle(3);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_leds", leds, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_alu", {alu_a, alu_b, 2'b00, alu_op}, 0);
    tb_reset = 1'b1;
    idle(2);

    // Directed frames with known results.
    do_frame(8'h05, 8'h0A, 8'h20);
    check("t1_leds", leds, 8'h0F);
    do_display();
    do_frame(8'h64, 8'h64, 8'h22);
    check("t2_leds", leds, 8'h00);
    do_display();
    do_frame(8'h64, 8'h32, 8'h20);
    check("t3_leds", leds, 8'h96);
    check("t3_flags_model", exp_flags, 8'h02);
    do_display();

    // Inter-byte timeout after the A byte.
    fe0 = fe_cnt;
    send_byte(8'hCD);
    send_byte(8'h05);
    idle(999);
    check("tmo_not_early", frame_err, 0);
    check("tmo_state_waiting", state_dbg, ST_GET_B);
    idle(1);
    check("tmo_pulse", frame_err, 1);
    check("tmo_state_idle", state_dbg, ST_IDLE);
    check("tmo_leds_kept", leds, exp_res);
    check("tmo_alu_a_kept", alu_a, 8'h05);
    check("tmo_alu_b_kept", alu_b, exp_b);
    idle(2);
    check("tmo_err_count", fe_cnt - fe0, 1);
    exp_a = 8'h05;
    do_frame(8'h11, 8'h22, 8'h26);

    // Unknown byte in IDLE; byte dropped during WAIT_RES.
    do_junk();
    fe0 = fe_cnt;
    exp_q.push_back(exp_res);
    exp_q.push_back(exp_flags);
    send_byte(8'hD1);
    wait_state("reach_wait_res", ST_WAIT_RES);
    send_byte(8'h77);
    idle(1);
    check("drop_frame_err", fe_cnt - fe0, 1);
    wait_tx_done("drop_tx_complete");
    check("drop_alu_a", alu_a, exp_a);

    // Randomised traffic; command values also appear as data bytes.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 4))
        0, 1: do_frame(8'(($urandom_range(0, 255))), 8'(($urandom_range(0, 255))),
                       {2'($urandom_range(0, 3)), ops[$urandom_range(0, 5)]});
        2:    do_frame(8'hCD, 8'hD1, {2'($urandom_range(0, 3)), ops[$urandom_range(0, 5)]});
        3:    do_display();
        default: do_junk();
      endcase
    end
    do_display();

    // Asynchronous reset mid GET_B.
    send_byte(8'hCD);
    send_byte(8'h3C);
    @(negedge clk);
    #2 tb_reset = 1'b0;
    #1;
    check("rstb_state", state_dbg, ST_IDLE);
    check("rstb_alu_a", alu_a, 0);
    check("rstb_leds", leds, 0);
    model_reset();
    idle(3);
    tb_reset = 1'b1;
    idle(2);

    // Asynchronous reset mid WAIT_FLG.
    do_frame(8'h81, 8'h7E, 8'h20);
    exp_q.push_back(exp_res);
    exp_q.push_back(exp_flags);
    send_byte(8'hD1);
    wait_state("reach_wait_flg", ST_WAIT_FLG);
    #2 tb_reset = 1'b0;
    #1;
    check("rstf_state", state_dbg, ST_IDLE);
    check("rstf_tx_data", tx_data, 0);
    check("rstf_tx_start", tx_start, 0);
    check("rstf_leds", leds, 0);
    check("rstf_alu", {alu_a, alu_b, 2'b00, alu_op}, 0);
    model_reset();
    idle(3);
    tb_reset = 1'b1;
    idle(12);
    do_display();
    check("post_rst_leds", leds, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time limit.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
